dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_LOCK, default 4, max consecutive locked grants to the loader while the core is waiting.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 c_req  in  1  core load/store request; c_we, c_adr, c_wdata held stable until c_gnt.
REQ-005 c_we  in  1  core write enable (1 = store, 0 = load).
REQ-006 c_adr  in  32  core byte address.
REQ-007 c_wdata  in  32  core store data.
REQ-008 c_gnt  out  1  core access performed this cycle.
REQ-009 c_stall  out  1  c_req & ~c_gnt; the core freezes its PC while high.
REQ-010 c_rvalid  out  1  core load data valid on c_rdata.
REQ-011 c_rdata  out  32  core load data.
REQ-012 l_req, l_we, l_lock  in  1 each  loader request, write enable, burst lock.
REQ-013 l_adr, l_wdata  in  32 each  loader address and store data.
REQ-014 l_gnt, l_rvalid, l_err  out  1 each  loader grant, read valid, misalignment error.
REQ-015 l_rdata  out  32  loader load data.
REQ-016 m_en, m_we  out  1 each  memory enable and write enable.
REQ-017 m_adr, m_wdata  out  32 each  memory address and write data.
REQ-018 m_rdata  in  32  memory read data; valid one cycle after a read with m_en=1.

Function
REQ-019 c_gnt and l_gnt shall be combinational from the registered state and the current requests, and shall never both be high.
REQ-020 With exactly one requester active, that requester shall be granted in the same cycle.
REQ-021 With both active, the requester selected by the 1-bit priority register prio shall be granted (0 = core, 1 = loader).
REQ-022 After every grant, prio shall point to the requester that was not granted.
REQ-023 Lock exception: if the loader was granted with l_lock=1 and lock_cnt < MAX_LOCK, the next contended cycle shall grant the loader.
REQ-024 lock_cnt shall increment on each locked loader grant while c_req=1.
REQ-025 lock_cnt shall clear on any core grant or when l_lock=0.
REQ-026 When lock_cnt reaches MAX_LOCK, the core shall be granted on its next request.
REQ-027 m_en shall equal c_gnt | l_gnt; m_we, m_adr and m_wdata shall be muxed from the granted requester; with no grant, m_we=0 and m_adr=m_wdata=0.
REQ-028 Loader access with l_adr[1:0] != 0: grant and arbitration state update proceed normally, but m_en=0 and l_err pulses high for that cycle.
REQ-029 Core address alignment shall not be checked.
REQ-030 x_rvalid shall be registered as (x_gnt & ~x_we), one cycle after the grant.
REQ-031 c_rdata and l_rdata shall both carry m_rdata.
REQ-032 A write shall complete in its grant cycle; no write response is generated.
REQ-033 Back-to-back grants to the same requester shall be legal every cycle; read latency shall be 1 cycle regardless of contention.

Reset
REQ-034 While reset=1: c_gnt, l_gnt, m_en, m_we, c_rvalid, l_rvalid and l_err shall be 0.
REQ-035 The register state prio=0, lock_cnt=0 and the rvalid registers shall clear on the first rising edge with reset=1.
REQ-036 Reset asserted mid-burst shall abandon the lock; no rvalid shall be produced for a read granted in the cycle reset rises.

Verification
REQ-037 Core only: c_req=1, c_we=1, c_adr=84, c_wdata=71 -> same cycle c_gnt=1, m_en=1, m_we=1, m_adr=84, m_wdata=71, c_stall=0.
REQ-038 Contention after reset: both request reads -> core granted first, loader next cycle; c_rvalid and l_rvalid pulse on consecutive cycles with c_stall=1 for 0 cycles.
REQ-039 Round robin: both request continuously without lock -> grants alternate C,L,C,L for 8 cycles.
REQ-040 Lock burst: MAX_LOCK=4, l_lock=1, both requesting -> loader granted 1 + 4 cycles, then core granted; c_stall high exactly 5 cycles.
REQ-041 Misaligned loader write: l_adr=0x82 -> l_gnt=1, l_err=1, m_en=0, memory contents unchanged.
REQ-042 Reset mid-burst: assert reset during the 3rd locked grant -> all grants and m_en are 0 during reset; after release, core wins first contention.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core, the loader, the data memory and the arbiter.
// The arbiter sits on the slave side; the environment (requesters plus memory) drives the master side.
interface dmem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_adr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_stall;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        l_req;
    logic        l_we;
    logic        l_lock;
    logic [31:0] l_adr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic        l_err;
    logic [31:0] l_rdata;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_adr, c_wdata,
        input  l_req, l_we, l_lock, l_adr, l_wdata,
        input  m_rdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        output l_gnt, l_rvalid, l_err, l_rdata,
        output m_en, m_we, m_adr, m_wdata
    );

    modport master (
        output c_req, c_we, c_adr, c_wdata,
        output l_req, l_we, l_lock, l_adr, l_wdata,
        output m_rdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        input  l_gnt, l_rvalid, l_err, l_rdata,
        input  m_en, m_we, m_adr, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core and a loader: round-robin
// priority with a bounded loader burst lock and a 1-cycle registered read-valid.
module dmem_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          prio_q, prio_d;
    logic          lockActive_q, lockActive_d;
    logic [CW-1:0] lockCnt_q, lockCnt_d;
    logic          cRvalid_q, cRvalid_d;
    logic          lRvalid_q, lRvalid_d;

    logic cGnt;
    logic lGnt;
    logic lockHold;
    logic lMisaligned;

    assign lMisaligned = (bus.l_adr[1:0] != 2'b00);

    // The loader keeps the port on contention only while its burst is still
    // within budget; lockCnt counts just those lock-extended grants.
    always_comb begin
        lockHold = lockActive_q & bus.l_lock & (lockCnt_q < CW'(MAX_LOCK));
        cGnt     = 1'b0;
        lGnt     = 1'b0;
        if (!reset) begin
            if (bus.c_req && bus.l_req) begin
                if (lockHold || prio_q) begin
                    lGnt = 1'b1;
                end else begin
                    cGnt = 1'b1;
                end
            end else begin
                cGnt = bus.c_req;
                lGnt = bus.l_req;
            end
        end
    end

    always_comb begin
        prio_d       = prio_q;
        lockActive_d = lockActive_q;
        lockCnt_d    = lockCnt_q;
        if (cGnt) begin
            prio_d = 1'b1;
        end else if (lGnt) begin
            prio_d = 1'b0;
        end
        if (cGnt || !bus.l_lock) begin
            lockActive_d = 1'b0;
            lockCnt_d    = '0;
        end else if (lGnt) begin
            lockActive_d = 1'b1;
            if (bus.c_req && lockHold) begin
                lockCnt_d = lockCnt_q + 1'b1;
            end
        end
        cRvalid_d = cGnt & ~bus.c_we;
        lRvalid_d = lGnt & ~bus.l_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q       <= 1'b0;
            lockActive_q <= 1'b0;
            lockCnt_q    <= '0;
            cRvalid_q    <= 1'b0;
            lRvalid_q    <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            lockActive_q <= lockActive_d;
            lockCnt_q    <= lockCnt_d;
            cRvalid_q    <= cRvalid_d;
            lRvalid_q    <= lRvalid_d;
        end
    end

    // A misaligned loader access is still granted, but never reaches memory.
    always_comb begin
        bus.m_en    = cGnt | (lGnt & ~lMisaligned);
        bus.m_we    = 1'b0;
        bus.m_adr   = '0;
        bus.m_wdata = '0;
        if (cGnt) begin
            bus.m_we    = bus.c_we;
            bus.m_adr   = bus.c_adr;
            bus.m_wdata = bus.c_wdata;
        end else if (lGnt) begin
            bus.m_we    = bus.l_we;
            bus.m_adr   = bus.l_adr;
            bus.m_wdata = bus.l_wdata;
        end
    end

    assign bus.c_gnt    = cGnt;
    assign bus.c_stall  = bus.c_req & ~cGnt;
    assign bus.c_rvalid = cRvalid_q;
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.l_gnt    = lGnt;
    assign bus.l_err    = lGnt & lMisaligned;
    assign bus.l_rvalid = lRvalid_q;
    assign bus.l_rdata  = bus.m_rdata;

endmodule
